mem_refill_arbiter: RTL

//  Shares the single SoC memory port between the I-cache refill path and the D-cache

---
 rtl/mem_refill_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_refill_arbiter.sv
// Arbitrates the single memory port between I-cache refills and D-cache refill/write-back
// bursts, generating per-beat word addresses and routing read data to the burst owner.
module mem_refill_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_req,
  input  logic [ADDR_W-1:0]            i_addr,
  output logic                         i_gnt,
  output logic                         i_rvalid,
  output logic [DATA_W-1:0]            i_rdata,
  output logic                         i_done,
  input  logic                         d_req,
  input  logic                         d_we,
  input  logic [ADDR_W-1:0]            d_addr,
  input  logic [DATA_W-1:0]            d_wdata,
  output logic [$clog2(BURST_LEN)-1:0] d_beat,
  output logic                         d_gnt,
  output logic                         d_rvalid,
  output logic [DATA_W-1:0]            d_rdata,
  output logic                         d_done,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_ready,
  input  logic                         mem_rvalid,
  input  logic [DATA_W-1:0]            mem_rdata
);

  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam int CNT_W  = BEAT_W + 1;
  localparam logic [CNT_W-1:0]  FULL      = CNT_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(BURST_LEN * 4 - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_e;

  state_e              state_q, state_d;
  logic                last_owner_q, last_owner_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                we_q, we_d;
  logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]    ret_cnt_q, ret_cnt_d;

  logic busy;
  logic accept;
  logic rd_ret;
  logic pick_d;

  assign busy    = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign mem_req = busy && (issue_cnt_q != FULL);
  assign mem_we  = mem_req && we_q;
  assign accept  = mem_req && mem_ready;
  assign rd_ret  = busy && !we_q && mem_rvalid;

  // last_owner: 0 = I-side, 1 = D-side; on contention the side that did not go last wins
  assign pick_d = (i_req && d_req) ? !last_owner_q : d_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b0;
      base_q       <= '0;
      we_q         <= 1'b0;
      issue_cnt_q  <= '0;
      ret_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      base_q       <= base_d;
      we_q         <= we_d;
      issue_cnt_q  <= issue_cnt_d;
      ret_cnt_q    <= ret_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    base_d       = base_q;
    we_d         = we_q;
    issue_cnt_d  = issue_cnt_q;
    ret_cnt_d    = ret_cnt_q;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d      = pick_d ? BUSY_D : BUSY_I;
          last_owner_d = pick_d;
          base_d       = (pick_d ? d_addr : i_addr) & ~LINE_MASK;
          we_d         = pick_d && d_we;
          issue_cnt_d  = '0;
          ret_cnt_d    = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        issue_cnt_d = issue_cnt_q + CNT_W'(accept);
        ret_cnt_d   = ret_cnt_q + CNT_W'(rd_ret);
        // Writes finish on the last accepted beat, reads on the last returned word
        if (we_q ? (issue_cnt_d == FULL) : (ret_cnt_d == FULL)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign i_gnt     = (state_q == BUSY_I);
  assign d_gnt     = (state_q == BUSY_D);
  assign i_rvalid  = i_gnt && mem_rvalid;
  assign i_rdata   = i_gnt ? mem_rdata : '0;
  assign d_rvalid  = d_gnt && !we_q && mem_rvalid;
  assign d_rdata   = (d_gnt && !we_q) ? mem_rdata : '0;
  assign i_done    = (state_q == DONE) && !last_owner_q;
  assign d_done    = (state_q == DONE) && last_owner_q;
  assign mem_addr  = base_q + (ADDR_W'(issue_cnt_q) << 2);
  assign mem_wdata = mem_we ? d_wdata : '0;
  assign d_beat    = issue_cnt_q[BEAT_W-1:0];

endmodule
